// File: rtl/mont_pkg.sv
// ---------------------------------------------------------------------------
// mont_pkg: shared state encoding and chunk constants for the Montgomery sequencer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mont_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    ACC_B    = 3'd2,
    ACC_M    = 3'd3,
    COLLAPSE = 3'd4,
    SUB      = 3'd5,
    DONE     = 3'd6
  } state_e;

  localparam logic [3:0] CHUNK_IDLE     = 4'd8;
  localparam logic [3:0] CHUNK_LAST     = 4'd5;
  localparam int         N_BITS_DEFAULT = 512;
  localparam int         ITER_W         = $clog2(N_BITS_DEFAULT / 2);

  // Iteration counter width for an arbitrary operand width; never below 1 bit.
  function automatic int iter_width(input int n_bits);
    int w;
    w = $clog2(n_bits / 2);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mont_chunk_counter.sv
// ---------------------------------------------------------------------------
// mont_chunk_counter: chunk index for collapse/subtract; holds CHUNK_IDLE when unused.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mont_chunk_counter
  import mont_pkg::*;
#(
  parameter logic [3:0] LAST = CHUNK_LAST
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       idle_i,
  input  logic       zero_i,
  input  logic       en_i,
  output logic [3:0] sel_o,
  output logic       last_o
);

  logic [3:0] sel_q;
  logic [3:0] sel_d;

  always_comb begin
    sel_d = sel_q;
    if (idle_i) begin
      sel_d = CHUNK_IDLE;
    end else if (zero_i) begin
      sel_d = 4'd0;
    end else if (en_i) begin
      sel_d = (sel_q == LAST) ? 4'd0 : sel_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sel_q <= CHUNK_IDLE;
    end else begin
      sel_q <= sel_d;
    end
  end

  assign sel_o  = sel_q;
  assign last_o = (sel_q == LAST);

endmodule

`default_nettype wire

// File: rtl/mont_sequencer.sv
// ---------------------------------------------------------------------------
// mont_sequencer: drives the carry-save Montgomery adder through accumulate,
// collapse and conditional-subtract phases. MONT_SUB_GUARD_EN adds sub_error.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mont_sequencer
  import mont_pkg::*;
#(
  parameter int N_BITS         = 512,
  parameter int N_CHUNKS       = 5,
  parameter int MAX_SUB_ROUNDS = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic [N_BITS-1:0] in_a,
  input  logic              c_zero,
  input  logic              c_one,
  input  logic              sub_finished,
  output logic              acc_clear,
  output logic              enable_c,
  output logic              c_doubleshift,
  output logic              subtract,
  output logic [3:0]        chunk_sel,
  output logic [1:0]        b_sel,
  output logic [1:0]        m_sel,
  output logic              busy,
  output logic              done
`ifdef MONT_SUB_GUARD_EN
  ,
  output logic              sub_error
`endif
);

  localparam int             IW        = iter_width(N_BITS);
  localparam logic [IW-1:0]  ITER_LAST = IW'(N_BITS / 2 - 1);

  state_e            state_q, state_d;
  logic              start_q, start_d;
  logic [N_BITS-1:0] a_q, a_d;
  logic [IW-1:0]     iter_q, iter_d;
  logic              chunk_last;
  logic              guard_trip;

  mont_chunk_counter #(
    .LAST (4'(N_CHUNKS))
  ) u_chunk (
    .clk    (clk),
    .resetn (resetn),
    .idle_i (!(state_d inside {COLLAPSE, SUB})),
    .zero_i ((state_d == COLLAPSE) && (state_q != COLLAPSE)),
    .en_i   (state_q inside {COLLAPSE, SUB}),
    .sel_o  (chunk_sel),
    .last_o (chunk_last)
  );

`ifdef MONT_SUB_GUARD_EN
  localparam int            RW         = (MAX_SUB_ROUNDS > 1) ? $clog2(MAX_SUB_ROUNDS) : 1;
  localparam logic [RW-1:0] ROUND_LAST = RW'(MAX_SUB_ROUNDS - 1);
  logic [RW-1:0] round_q, round_d;
  logic          sub_error_q, sub_error_d;
  wire           round_limit = (round_q == ROUND_LAST);
`else
  wire           round_limit = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    start_d       = start_q;
    a_d           = a_q;
    iter_d        = iter_q;
    acc_clear     = 1'b0;
    enable_c      = 1'b0;
    c_doubleshift = 1'b0;
    subtract      = 1'b0;
    b_sel         = 2'b00;
    m_sel         = 2'b00;
    done          = 1'b0;
    guard_trip    = 1'b0;
    case (state_q)
      IDLE: begin
        // start is registered for one cycle before the multiply begins
        if (start_q) begin
          start_d = 1'b0;
          state_d = LOAD;
        end else if (start) begin
          start_d = 1'b1;
          a_d     = in_a;
        end
      end
      LOAD: begin
        acc_clear = 1'b1;
        iter_d    = '0;
        state_d   = ACC_B;
      end
      ACC_B: begin
        enable_c = 1'b1;
        b_sel    = a_q[1:0];
        state_d  = ACC_M;
      end
      ACC_M: begin
        c_doubleshift = 1'b1;
        m_sel         = {c_one, c_zero};
        a_d           = a_q >> 2;
        iter_d        = iter_q + 1'b1;
        state_d       = (iter_q == ITER_LAST) ? COLLAPSE : ACC_B;
      end
      COLLAPSE: begin
        if (chunk_last) state_d = SUB;
      end
      SUB: begin
        subtract = 1'b1;
        // completion is only honoured on the last chunk of a round
        if (chunk_last) begin
          if (sub_finished) begin
            state_d = DONE;
          end else if (round_limit) begin
            state_d    = DONE;
            guard_trip = 1'b1;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      a_q     <= '0;
      iter_q  <= '0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      a_q     <= a_d;
      iter_q  <= iter_d;
    end
  end

  assign busy = (state_q != IDLE) || start_q;

`ifdef MONT_SUB_GUARD_EN
  always_comb begin
    round_d     = round_q;
    sub_error_d = sub_error_q;
    if (state_q == COLLAPSE) begin
      round_d = '0;
    end else if ((state_q == SUB) && chunk_last) begin
      round_d = round_q + 1'b1;
    end
    if (guard_trip) begin
      sub_error_d = 1'b1;
    end else if ((state_q == IDLE) && !start_q && start) begin
      sub_error_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      round_q     <= '0;
      sub_error_q <= 1'b0;
    end else begin
      round_q     <= round_d;
      sub_error_q <= sub_error_d;
    end
  end

  assign sub_error = sub_error_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mont_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mont_sequencer: cycle-trace model of one multiply compared against the DUT.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mont_sequencer;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          resetn, start, c_zero, c_one, sub_finished;
  logic [NB-1:0] in_a;
  logic          acc_clear, enable_c, c_doubleshift, subtract, busy, done;
  logic [3:0]    chunk_sel;
  logic [1:0]    b_sel, m_sel;
`ifdef MONT_SUB_GUARD_EN
  logic          sub_error;
`endif

  int checks   = 0;
  int failures = 0;

  logic [13:0] tr [0:63];
  bit          sf [0:63];
  int          tr_len;
  logic [13:0] exp_v;
  bit          chk_en  = 1'b0;
  bit          exp_err = 1'b0;
  logic [13:0] dut_v;

  always #5 clk = ~clk;

  mont_sequencer #(
    .N_BITS         (NB),
    .N_CHUNKS       (5),
    .MAX_SUB_ROUNDS (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .in_a          (in_a),
    .c_zero        (c_zero),
    .c_one         (c_one),
    .sub_finished  (sub_finished),
    .acc_clear     (acc_clear),
    .enable_c      (enable_c),
    .c_doubleshift (c_doubleshift),
    .subtract      (subtract),
    .chunk_sel     (chunk_sel),
    .b_sel         (b_sel),
    .m_sel         (m_sel),
    .busy          (busy),
    .done          (done)
`ifdef MONT_SUB_GUARD_EN
    ,
    .sub_error     (sub_error)
`endif
  );

  assign dut_v = {acc_clear, enable_c, c_doubleshift, subtract, chunk_sel, b_sel, m_sel, busy, done};

  function automatic logic [13:0] mk(input bit ac, input bit ec, input bit cd, input bit sb,
                                     input logic [3:0] ch, input logic [1:0] b, input logic [1:0] m,
                                     input bit bz, input bit dn);
    return {ac, ec, cd, sb, ch, b, m, bz, dn};
  endfunction

  localparam logic [13:0] IDLE_V = 14'b0000_1000_0000_00;

  // Expected per-cycle trace, cycle 0 being the one right after the start edge.
  task automatic build(input logic [NB-1:0] a, input logic cz, input logic co,
                       input int rounds, input bit noise, input bit gerr);
    int n;
    logic [NB-1:0] sh;
    n = 0;
    tr[n] = mk(0,0,0,0,4'd8,2'd0,2'd0,1,0); sf[n] = 0; n++;
    tr[n] = mk(1,0,0,0,4'd8,2'd0,2'd0,1,0); sf[n] = 0; n++;
    for (int i = 0; i < NB/2; i++) begin
      sh = a >> (2*i);
      tr[n] = mk(0,1,0,0,4'd8,sh[1:0],2'd0,1,0);      sf[n] = 0; n++;
      tr[n] = mk(0,0,1,0,4'd8,2'd0,{co,cz},1,0);      sf[n] = 0; n++;
    end
    for (int c = 0; c < 6; c++) begin
      tr[n] = mk(0,0,0,0,4'(c),2'd0,2'd0,1,0); sf[n] = 0; n++;
    end
    for (int r = 0; r < rounds; r++) begin
      for (int c = 0; c < 6; c++) begin
        tr[n] = mk(0,0,0,1,4'(c),2'd0,2'd0,1,0);
        sf[n] = (c == 5) ? (r == rounds-1 && !gerr) : noise;
        n++;
      end
    end
    tr[n] = mk(0,0,0,0,4'd8,2'd0,2'd0,1,1); sf[n] = 0; n++;
    tr_len = n;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (dut_v !== exp_v) begin
        failures++;
        $display("FAIL outputs @%0t got=%h exp=%h", $time, dut_v, exp_v);
      end
`ifdef MONT_SUB_GUARD_EN
      checks++;
      if (sub_error !== exp_err) begin
        failures++;
        $display("FAIL sub_error @%0t got=%b exp=%b", $time, sub_error, exp_err);
      end
`endif
    end
  end

  task automatic check_int(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", name, got, expv);
    end
  endtask

  task automatic run_op(input logic [NB-1:0] a, input logic cz, input logic co, input int rounds,
                        input bit noise, input bit gerr, input int rst_at, input int exp_lat,
                        input bit chk_b);
    int lat;
    int nb;
    logic [1:0] bseq [0:3];
    build(a, cz, co, rounds, noise, gerr);
    start = 1'b1; in_a = a; c_zero = cz; c_one = co;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    nb  = 0;
    for (int t = 0; t < tr_len; t++) begin
      exp_v        = tr[t];
      sub_finished = sf[t];
      start        = (t == 5);
      in_a         = 8'h5A;
      if (t == 0) exp_err = 1'b0;
      if (gerr && t == tr_len-1) exp_err = 1'b1;
      if (t == rst_at) resetn = 1'b0;
      @(negedge clk);
      if (done === 1'b1 && lat < 0) lat = t + 1;
      if (enable_c === 1'b1 && nb < 4) begin
        bseq[nb] = b_sel;
        nb++;
      end
      @(posedge clk); #1;
      if (t == rst_at) begin
        resetn  = 1'b1;
        exp_err = 1'b0;
        break;
      end
    end
    exp_v = IDLE_V; sub_finished = 1'b0; start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done === 1'b1 && lat < 0) lat = -2;
      @(posedge clk); #1;
    end
    check_int("latency", lat, exp_lat);
    if (chk_b) begin
      check_int("b_sel[0]", int'(bseq[0]), 0);
      check_int("b_sel[1]", int'(bseq[1]), 3);
      check_int("b_sel[2]", int'(bseq[2]), 1);
      check_int("b_sel[3]", int'(bseq[3]), 2);
    end
  endtask

  initial begin
    resetn = 1'b0; start = 1'b1; in_a = 8'hFF;
    c_zero = 1'b0; c_one = 1'b0; sub_finished = 1'b0;
    exp_v  = IDLE_V;
    @(posedge clk); #1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset chunk_sel", int'(chunk_sel), 8);
    start = 1'b0; resetn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_int("busy after reset", int'(busy), 0);

    run_op(8'b10_01_11_00, 1'b0, 1'b0, 1, 1'b0, 1'b0, -1, 23, 1'b1);
    run_op(8'b10_01_11_00, 1'b0, 1'b1, 1, 1'b0, 1'b0, -1, 23, 1'b1);
    run_op(8'b10_01_11_00, 1'b1, 1'b1, 3, 1'b1, 1'b0, -1, 35, 1'b0);
    run_op(8'b10_01_11_00, 1'b0, 1'b0, 1, 1'b0, 1'b0, 19, -1, 1'b0);
`ifdef MONT_SUB_GUARD_EN
    run_op(8'b10_01_11_00, 1'b0, 1'b1, 4, 1'b0, 1'b1, -1, 41, 1'b0);
    run_op(8'b00_11_01_10, 1'b1, 1'b0, 1, 1'b0, 1'b0, -1, 23, 1'b0);
`endif
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mont_sequencer.md
Name: mont_sequencer

Overview:
- Control initiator for the carry-save Montgomery datapath. It drives the accumulator/collapse/subtract adder through one full multiply.
- Sequence per multiply: radix-4 accumulate loop, then chunked carry-save collapse, then repeated chunked conditional subtraction until the adder reports completion.
- Sits between the AXI/top-level controller (start/done) and the adder's control inputs.

Parameters:
- N_BITS, 512: operand width; number of radix-4 iterations = N_BITS/2.
- N_CHUNKS, 5: collapse/subtract chunks; chunk_sel counts 0..N_CHUNKS.
- MAX_SUB_ROUNDS, 4: subtract rounds allowed before the guard fires (used only with the optional feature).

Ports:
- clk  in  1  system clock
- resetn  in  1  synchronous active-low reset
- start  in  1  begin a multiply; sampled only in IDLE
- in_a  in  N_BITS  multiplier operand A, latched on start
- c_zero  in  1  adder quotient flag, bit 0
- c_one  in  1  adder quotient flag, bit 1
- sub_finished  in  1  adder subtraction-complete pulse
- acc_clear  out  1  one-cycle pulse; the top level ANDs it, inverted, into the adder reset
- enable_c  out  1  load C without shift (add a_digit*B)
- c_doubleshift  out  1  load C shifted by 2 (add q*M)
- subtract  out  1  adder in subtract mode
- chunk_sel  out  4  chunk index; 4'd8 = idle/hold (bit 3 freezes the adder pipeline)
- b_sel  out  2  current radix-4 digit of A
- m_sel  out  2  quotient digit {c_one,c_zero}
- busy  out  1  high from start acceptance until done
- done  out  1  one-cycle completion pulse

Behaviour:
- Reset values: all outputs 0 except chunk_sel = 4'd8. FSM goes to IDLE, counters go to 0.
- Reset mid-operation: the next cycle is IDLE with reset values. No done pulse is generated.
- IDLE:
  - start=1 → LOAD. Latch in_a into a_reg; busy goes high next cycle.
  - start while busy is ignored; it is not queued.
- LOAD (1 cycle): acc_clear=1, iter=0 → ACC_B.
- ACC_B (1 cycle): enable_c=1, b_sel=a_reg[1:0] → ACC_M.
- ACC_M (1 cycle):
  - c_doubleshift=1, m_sel={c_one,c_zero}, sampled combinationally this cycle.
  - a_reg shifts right by 2; iter increments.
  - If iter == N_BITS/2-1 → COLLAPSE, else → ACC_B.
- Accumulate phase: exactly N_BITS cycles (512 at default). enable_c and c_doubleshift are never high together.
- COLLAPSE: subtract=0, chunk_sel steps 0,1,…,N_CHUNKS (6 cycles) → SUB with chunk_sel=0.
- SUB:
  - subtract=1; chunk_sel cycles 0..N_CHUNKS.
  - At chunk_sel==N_CHUNKS with sub_finished=1 → DONE; without it, chunk_sel wraps to 0 (new round, round counter +1).
  - sub_finished seen at any other chunk_sel is ignored.
- DONE (1 cycle): done=1, subtract=0, chunk_sel=8, busy still 1 → IDLE.
- Outside COLLAPSE/SUB, chunk_sel=8.
- Total latency, start to done, for k subtract rounds: 1 (LOAD) + N_BITS + (N_CHUNKS+1) + k*(N_CHUNKS+1) + 1 cycles, plus 1 cycle of start registration.

Optional Feature:
- MONT_SUB_GUARD_EN defined:
  - Adds output sub_error (1 bit, reset 0).
  - If the round counter reaches MAX_SUB_ROUNDS without sub_finished, the FSM goes to DONE, pulses done, and sets sub_error=1.
  - sub_error holds until the next accepted start.
- Undefined: no port; SUB loops indefinitely until sub_finished.

Decomposition:
- Package mont_pkg holds:
  - state enum {IDLE, LOAD, ACC_B, ACC_M, COLLAPSE, SUB, DONE}
  - CHUNK_IDLE=4'd8, CHUNK_LAST=4'd5
  - ITER_W=$clog2(N_BITS/2)
- Sub-module mont_chunk_counter: 4-bit counter with enable, wrap at CHUNK_LAST, idle load to CHUNK_IDLE, last flag. Shared by COLLAPSE and SUB.

Test Plan:
- Reset then idle → all outputs 0, chunk_sel=8; start with resetn=0 is ignored.
- N_BITS=8, in_a=8'b10_01_11_00, flags tied 0, sub_finished at the first round's sel 5 → b_sel sequence 0,3,1,2; done 23 cycles after the start edge.
- Same as above with c_one=1,c_zero=0 → m_sel=2'b10 on every ACC_M cycle; enable_c/c_doubleshift alternate, never overlapping.
- sub_finished withheld for 2 rounds → chunk_sel 0..5 repeated 3 times; done 12 cycles later than the single-round case.
- resetn pulsed low during SUB at chunk_sel=3 → next cycle IDLE, chunk_sel=8, busy=0, no done.
- MONT_SUB_GUARD_EN, sub_finished never asserted → done after 4 rounds, sub_error=1; cleared on the next start.
